qlal3_mult_arbiter: RTL and testbench

// - Shares one hard 32x32 multiplier (ASSPL Amult0/Bmult0/Cmult0 or ASSPR Amult1/Bmult1/Cmult1) among N_REQ fabric requesters.
// - Runs round-robin arbitration and a valid/ready request handshake.
// - Sequences Valid_mult, then captures and routes each 64-bit product back to its originating requester.
// - Sits in fabric between user datapaths and the multiplier ports of the ASSP macro.

---
 rtl/qlal3_mult_arbiter.sv | 157 +++++++++++++++
 tb/tb_qlal3_mult_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlal3_mult_arbiter.sv
// Round-robin arbiter that time-shares one hard 32x32 multiplier among N_REQ
// fabric requesters, routing each 64-bit product back to the requester that issued it.
module qlal3_mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [63:0]           rsp_data,
  output logic                  busy,
  output logic [31:0]           Amult,
  output logic [31:0]           Bmult,
  output logic                  Valid_mult,
  input  logic [63:0]           Cmult
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(MULT_LAT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [IW-1:0]      owner_reg, owner_next;
  logic [IW-1:0]      ptr_reg, ptr_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        b_reg, b_next;
  logic               valid_mult_reg, valid_mult_next;
  logic               busy_reg, busy_next;
  logic [N_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
  logic [63:0]        rsp_data_reg, rsp_data_next;

  logic [31:0]        a_arr [N_REQ];
  logic [31:0]        b_arr [N_REQ];
  logic               grant_found;
  logic [IW-1:0]      grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Search starts at the pointer and wraps, so the last winner is checked last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[IW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // Gated by RESET_n so the accept strobe is low for the whole reset interval.
  always_comb begin
    req_ready = '0;
    if (RESET_n && (state_reg == IDLE) && grant_found) req_ready = onehot(grant_idx);
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    owner_next      = owner_reg;
    ptr_next        = ptr_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    valid_mult_next = valid_mult_reg;
    busy_next       = busy_reg;
    rsp_valid_next  = '0;
    rsp_data_next   = rsp_data_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          a_next          = a_arr[grant_idx];
          b_next          = b_arr[grant_idx];
          owner_next      = grant_idx;
          ptr_next        = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          count_next      = COUNT_INIT;
          valid_mult_next = 1'b1;
          busy_next       = 1'b1;
          state_next      = BUSY;
        end
      end
      BUSY: begin
        if (count_reg == '0) begin
          rsp_data_next   = Cmult;
          rsp_valid_next  = onehot(owner_reg);
          valid_mult_next = 1'b0;
          busy_next       = 1'b0;
          state_next      = IDLE;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      owner_reg      <= '0;
      ptr_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      valid_mult_reg <= 1'b0;
      busy_reg       <= 1'b0;
      rsp_valid_reg  <= '0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      owner_reg      <= owner_next;
      ptr_reg        <= ptr_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      valid_mult_reg <= valid_mult_next;
      busy_reg       <= busy_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_data_reg   <= rsp_data_next;
    end
  end

  assign Amult      = a_reg;
  assign Bmult      = b_reg;
  assign Valid_mult = valid_mult_reg;
  assign busy       = busy_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;

endmodule

// File: tb/tb_qlal3_mult_arbiter.sv
// Directed bench for qlal3_mult_arbiter (N_REQ=4, MULT_LAT=2) with a multiplier model
// that only presents a valid product in the last Valid_mult cycle.
module tb_qlal3_mult_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic            CLK = 1'b0;
  logic            RESET_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [63:0]     rsp_data;
  logic            busy;
  logic [31:0]     Amult;
  logic [31:0]     Bmult;
  logic            Valid_mult;
  logic [63:0]     Cmult;

  int checks = 0;
  int errors = 0;

  qlal3_mult_arbiter #(.N_REQ(N), .MULT_LAT(LAT)) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .Amult      (Amult),
    .Bmult      (Bmult),
    .Valid_mult (Valid_mult),
    .Cmult      (Cmult)
  );

  always #5 CLK = ~CLK;

  // Product is only valid during the final Valid_mult cycle; any other sample sees junk.
  int vcnt = 0;
  always @(posedge CLK) vcnt <= Valid_mult ? vcnt + 1 : 0;
  always_comb begin
    if (Valid_mult && (vcnt == LAT - 1)) Cmult = {32'd0, Amult} * {32'd0, Bmult};
    else                                 Cmult = 64'hBADC_0FFE_E0DD_F00D;
  end

  task automatic apply_reset();
    RESET_n   = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (!ok && !busy && !Valid_mult) ok = 1'b1;
    end
  endtask

  // Drives one request, scrambles operands after acceptance, returns what came back.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        output logic [3:0] rdy, output logic [3:0] rsp,
                        output logic [63:0] dat, output int lat);
    logic done;
    @(negedge CLK);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid           = '0;
    req_valid[idx]      = 1'b1;
    #1 rdy = req_ready;
    @(posedge CLK);
    #1;
    req_valid = '0;
    req_a     = {N{32'hA5A5_5A5A}};
    req_b     = {N{32'h1234_5678}};
    rsp  = '0;
    dat  = '0;
    lat  = 0;
    done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (!done && rsp_valid != '0) begin
        rsp  = rsp_valid;
        dat  = rsp_data;
        lat  = c;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RESET_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, busy, Amult, Bmult, Valid_mult} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b rsp_data=%h busy=%b A=%h B=%h vm=%b, required all zero",
               req_ready, rsp_valid, rsp_data, busy, Amult, Bmult, Valid_mult);
    end
    req_valid = 4'b1111;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || Valid_mult !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b vm=%b, required 0000/0", req_ready, Valid_mult);
    end
    $display("test_reset: ready=%b vm=%b", req_ready, Valid_mult);
    req_valid = '0;
    @(negedge CLK);
    RESET_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge CLK);
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd5;
    req_valid    = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready: got %b, required 0010", req_ready);
    end
    @(posedge CLK);
    #1 req_valid = '0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0000 || Valid_mult !== 1'b1 || busy !== 1'b1 || Amult !== 32'd3 ||
        Bmult !== 32'd5 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_cycle1: ready=%b vm=%b busy=%b A=%0d B=%0d rsp=%b, required 0000 1 1 3 5 0000",
               req_ready, Valid_mult, busy, Amult, Bmult, rsp_valid);
    end
    @(negedge CLK);
    checks++;
    if (Valid_mult !== 1'b1 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_cycle2: vm=%b rsp=%b, required 1 0000", Valid_mult, rsp_valid);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 64'd15 || Valid_mult !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: rsp=%b data=%0d vm=%b busy=%b, required 0010 15 0 0",
               rsp_valid, rsp_data, Valid_mult, busy);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 64'd15) begin
      errors++;
      $display("FAIL single_hold: rsp=%b data=%0d, required 0000 15", rsp_valid, rsp_data);
    end
    $display("test_single: req1 3*5 -> data=%0d", rsp_data);
  endtask

  task automatic test_corners();
    logic [3:0]  rdy, rsp;
    logic [63:0] dat;
    int          lat;
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, rsp, dat, lat);
    checks++;
    if (rdy !== 4'b0001 || rsp !== 4'b0001 || dat !== 64'hFFFF_FFFE_0000_0001 || lat != LAT + 1) begin
      errors++;
      $display("FAIL corner_max: ready=%b rsp=%b data=%h lat=%0d, required 0001 0001 fffffffe00000001 %0d",
               rdy, rsp, dat, lat, LAT + 1);
    end
    $display("test_corners: max*max -> %h", dat);
    run_op(2, 32'd0, 32'hDEAD_BEEF, rdy, rsp, dat, lat);
    checks++;
    if (rdy !== 4'b0100 || rsp !== 4'b0100 || dat !== 64'd0 || lat != LAT + 1) begin
      errors++;
      $display("FAIL corner_zero: ready=%b rsp=%b data=%h lat=%0d, required 0100 0100 0 %0d",
               rdy, rsp, dat, lat, LAT + 1);
    end
    $display("test_corners: 0*deadbeef -> %h", dat);
  endtask

  task automatic test_round_robin();
    logic [3:0]  g_hist [0:15];
    logic [3:0]  exp_g  [0:4];
    logic [63:0] exp_p  [0:3];
    logic [3:0]  grants [$];
    int          gcyc   [$];
    int          nrsp;
    int          owner;
    logic        ok;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_p = '{64'd10, 64'd40, 64'd90, 64'd160};
    RESET_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_a[32*k +: 32] = 32'(k + 1);
      req_b[32*k +: 32] = 32'(10 * (k + 1));
    end
    req_valid = 4'b1111;
    @(posedge CLK);
    #2 RESET_n = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      g_hist[c] = req_ready;
      if (req_ready != '0) begin
        grants.push_back(req_ready);
        gcyc.push_back(c);
      end
      if (rsp_valid != '0) begin
        nrsp++;
        owner = 0;
        for (int k = 0; k < N; k++) if (rsp_valid[k]) owner = k;
        checks++;
        if (c < 3 || rsp_valid !== g_hist[c-3] || rsp_data !== exp_p[owner]) begin
          errors++;
          $display("FAIL rr_rsp: cycle %0d rsp=%b data=%0d, required grant from 3 cycles earlier and data %0d",
                   c, rsp_valid, rsp_data, exp_p[owner]);
        end
        $display("test_round_robin: cycle %0d rsp=%b data=%0d", c, rsp_valid, rsp_data);
      end
    end
    req_valid = '0;
    checks++;
    if (grants.size() < 5 || nrsp != 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d rsps=%0d, required >=5 and 5", grants.size(), nrsp);
    end
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      checks++;
      if (grants[k] !== exp_g[k] || (k > 0 && gcyc[k] - gcyc[k-1] != LAT + 1)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b at cycle %0d, required %b spaced %0d cycles",
                 k, grants[k], gcyc[k], exp_g[k], LAT + 1);
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] grants [0:2];
    int         ngr;
    logic       ok;
    apply_reset();
    req_a[31:0]  = 32'd11;
    req_b[31:0]  = 32'd13;
    req_a[95:64] = 32'd2;
    req_b[95:64] = 32'd3;
    req_valid    = 4'b0001;
    ngr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (req_ready != '0 && ngr < 3) begin
        grants[ngr] = req_ready;
        ngr++;
        if (ngr == 3) req_valid = '0;
      end
      if (ngr >= 1 && ngr < 3 && busy) req_valid[2] = 1'b1;
    end
    req_valid = '0;
    checks++;
    if (ngr != 3 || grants[0] !== 4'b0001 || grants[1] !== 4'b0100 || grants[2] !== 4'b0001) begin
      errors++;
      $display("FAIL fairness: grants=%0d seq=%b,%b,%b, required 0001,0100,0001",
               ngr, grants[0], grants[1], grants[2]);
    end
    $display("test_fairness: seq=%b,%b,%b", grants[0], grants[1], grants[2]);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fair_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    logic spurious;
    @(negedge CLK);
    req_a[63:32] = 32'd6;
    req_b[63:32] = 32'd7;
    req_valid    = 4'b0010;
    @(posedge CLK);
    #1 req_valid = '0;
    @(negedge CLK);
    RESET_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, busy, Amult, Bmult, Valid_mult} !== '0) begin
      errors++;
      $display("FAIL midop_reset: ready=%b rsp=%b data=%h busy=%b A=%h B=%h vm=%b, required all zero",
               req_ready, rsp_valid, rsp_data, busy, Amult, Bmult, Valid_mult);
    end
    @(posedge CLK);
    @(negedge CLK);
    RESET_n  = 1'b1;
    spurious = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (rsp_valid != '0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL midop_spurious: rsp_valid seen after reset, required none");
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midop_pointer: ready=%b, required 0001", req_ready);
    end
    $display("test_reset_midop: ready after release=%b", req_ready);
    req_valid = '0;
  endtask

  task automatic test_operand_hold();
    logic done;
    int   lat;
    @(negedge CLK);
    req_a[127:96] = 32'd7;
    req_b[127:96] = 32'd9;
    req_valid     = 4'b1000;
    @(posedge CLK);
    #1;
    req_valid     = '0;
    req_a[127:96] = 32'd100;
    req_b[127:96] = 32'd200;
    @(negedge CLK);
    checks++;
    if (Amult !== 32'd7 || Bmult !== 32'd9) begin
      errors++;
      $display("FAIL hold_operands: A=%0d B=%0d, required 7 9", Amult, Bmult);
    end
    done = 1'b0;
    lat  = 1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge CLK);
      if (!done && rsp_valid != '0) begin
        done = 1'b1;
        lat  = c;
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 64'd63 || lat != LAT + 1) begin
          errors++;
          $display("FAIL hold_rsp: rsp=%b data=%h lat=%0d, required 1000 63 %0d",
                   rsp_valid, rsp_data, lat, LAT + 1);
        end
        $display("test_operand_hold: rsp=%b data=%0d lat=%0d", rsp_valid, rsp_data, lat);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL hold_timeout: no rsp_valid within 10 cycles, required one");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_round_robin();
    test_fairness();
    test_reset_midop();
    test_operand_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
